led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator driven by the PLL-derived system clock. A prescaler divides the clock by 2^LOG2DELAY to produce a step tick. Each tick advances one of four selectable display patterns: binary count, Gray count, bouncing one-hot scanner, or bouncing thermometer bar. It sits between the PLL wrapper (its `en` is driven by PLL `lock`) and the board LED pins, and replaces the fixed-width Gray-code counter in the top level.

## Interface

- `WIDTH`, 8: number of LEDs; legal range 2..32.
- `LOG2DELAY`, 22: prescaler width; tick period is 2^LOG2DELAY enabled cycles; legal range 1..30.

Ports:

- `clk` in 1: system clock (PLL global output).
- `rst` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `en` in 1: count enable, normally PLL `lock`. Low freezes all state.
- `mode` in 2: pattern select. 00 BIN, 01 GRAY, 10 SCAN, 11 BAR.
- `leds` out WIDTH: registered LED pattern; bit 0 = LED0.
- `tick` out 1: registered one-cycle step strobe.

## Operation

- **Prescaler**
  - `presc` is LOG2DELAY bits and increments each cycle while `en`=1, wrapping.
  - Tick condition: `presc` is all ones and `en`=1.
  - In a tick cycle, the registered `tick` is 1 in the following cycle. Pattern state advances at the same edge on which `presc` wraps.
- **Pattern state**
  - `cnt` (WIDTH bits), `pos` (0..WIDTH-1), `k` (0..WIDTH), and `dir` (0 = up, 1 = down).
  - Only the state of the active mode advances. All other state holds.
- **BIN**: `cnt` += 1 per step, wraps modulo 2^WIDTH. `leds` = `cnt`.
- **GRAY**: `cnt` += 1 per step, wraps. `leds` = `cnt` ^ (`cnt` >> 1).
- **SCAN**: `leds` = 1 << `pos`.
  - Up: `pos` += 1. On reaching WIDTH-1, `dir` becomes down.
  - Down: `pos` -= 1. On reaching 0, `dir` becomes up.
  - Endpoints are shown exactly once per sweep.
- **BAR**: `leds` = (1 << `k`) - 1, computed in WIDTH+1 bits and truncated.
  - `k` bounces between 0 and WIDTH using the same rule as SCAN.
  - Both all-off and all-on are shown once per sweep.
- **Mode change**
  - `mode` is registered into `mode_q` every cycle.
  - When `mode` != `mode_q`, that cycle performs a restart: `cnt`, `pos`, `k` and `presc` are cleared to 0, `dir` is set to up, and no tick is generated.
  - Restart has priority over tick and occurs regardless of `en`.
- **en low**
  - `presc`, `cnt`, `pos`, `k` and `dir` all hold. No tick is generated.
  - `leds` keeps showing the held state.
- **leds register**
  - Loaded every cycle with the pattern of the next-state value, under the current `mode`.
  - Therefore `leds` changes at the same edge the state advances.

## Timing

- **Reset**: `rst`=1 immediately forces the following, independent of `clk`:
  - `leds` = 0 and `tick` = 0.
  - `presc`, `cnt`, `pos` and `k` = 0; `dir` = up.
  - `mode_q` = 0 (BIN).
- **After reset release**: the first edge loads `leds` with the pattern of state 0 (BIN/GRAY/BAR: 0, SCAN: 0x01).
  - If `mode` != 00 at that point, the restart rule fires. This is harmless, since the state is already 0.
- **Tick spacing**: with `en` continuously 1, the first wrap occurs at edge number 2^LOG2DELAY after reset release. Later wraps follow every 2^LOG2DELAY edges.
  - `tick` is high for exactly 1 cycle, in the cycle after the wrap edge.
- **Latency**: `leds` shows step n+1 starting in the same cycle that `tick` is high.
- **Reset mid-operation**: reset aborts immediately. The sequence restarts from state 0 with a full prescaler period.
- **Mode change coincident with tick**: restart wins. The new mode starts at state 0, and its first step comes a full 2^LOG2DELAY enabled cycles later.
- **en falling on a wrap cycle**: no tick and no advance. The wrap happens after `en` returns to 1.

## Test plan

All scenarios use WIDTH=4, LOG2DELAY=2 (one step every 4 cycles) and `en`=1 unless stated.

- **BIN from reset**, mode=00: `leds` steps through 0,1,2,…,15,0. Each `tick` pulse is 1 cycle wide, with pulses 4 cycles apart.
- **GRAY**, mode=01: `leds` = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0. Exactly one bit changes per step.
- **SCAN**, mode=10: `leds` = 1,2,4,8,4,2,1,2,4. No repeated endpoint.
- **BAR**, mode=11: `leds` = 0,1,3,7,15,7,3,1,0,1.
- **en gating**: drop `en` for 10 cycles at BIN value 5. `leds` holds 5 and `tick` stays 0. The next step to 6 comes exactly the remaining prescaler cycles after `en` returns.
- **Mode switch and async reset**:
  - In BIN at value 9, switch to SCAN on a tick cycle. `leds` = 0x1, no `tick` that cycle, and the next step to 0x2 follows 4 cycles later.
  - Then assert `rst` between clock edges. `leds` goes to 0 without waiting for an edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// LED pattern generator. A free-running prescaler of LOG2DELAY bits produces a
// step every 2^LOG2DELAY enabled cycles. Each step advances one of four
// display patterns: binary count, Gray count, bouncing one-hot scanner or
// bouncing thermometer bar. Changing the pattern select restarts the new
// pattern from its first state with a full prescaler period.
//
// Parameters:
//   WIDTH      number of LEDs (2..32)
//   LOG2DELAY  prescaler width, step period 2^LOG2DELAY enabled cycles (1..30)
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   en    in   count enable (PLL lock); low freezes all pattern state
//   mode  in   pattern select: 00 BIN, 01 GRAY, 10 SCAN, 11 BAR
//   leds  out  registered LED pattern, bit 0 = LED0
//   tick  out  registered one-cycle step strobe
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int WIDTH     = 8,
   parameter int LOG2DELAY = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] leds,
   output logic             tick
);

   // pos spans 0..WIDTH-1, k spans 0..WIDTH (one extra value for all-on)
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int KW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      MODE_BIN  = 2'b00,
      MODE_GRAY = 2'b01,
      MODE_SCAN = 2'b10,
      MODE_BAR  = 2'b11
   } mode_e;

   logic [1:0]           mode_q;
   logic [LOG2DELAY-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]        pos_q, pos_d;
   logic [KW-1:0]        k_q, k_d;
   logic                 dir_q, dir_d;   // 0 = up, 1 = down
   logic [WIDTH-1:0]     leds_q, leds_d;
   logic                 tick_q, tick_d;

   logic restart;
   logic wrap;
   logic step;

   function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] c);
      return c ^ (c >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] scan_of(input logic [PW-1:0] p);
      logic [WIDTH-1:0] one;
      one = {{(WIDTH-1){1'b0}}, 1'b1};
      return one << p;
   endfunction

   // Built one bit wider so that k = WIDTH yields all ones after truncation
   function automatic logic [WIDTH-1:0] bar_of(input logic [KW-1:0] kk);
      logic [WIDTH:0] one;
      logic [WIDTH:0] b;
      one = {{WIDTH{1'b0}}, 1'b1};
      b   = (one << kk) - one;
      return b[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] pattern_of(
      input logic [1:0]       m,
      input logic [WIDTH-1:0] c,
      input logic [PW-1:0]    p,
      input logic [KW-1:0]    kk
   );
      logic [WIDTH-1:0] r;
      case (mode_e'(m))
         MODE_BIN:  r = c;
         MODE_GRAY: r = gray_of(c);
         MODE_SCAN: r = scan_of(p);
         default:   r = bar_of(kk);
      endcase
      return r;
   endfunction

   always_comb begin
      restart = (mode != mode_q);
      wrap    = en && (presc_q == '1);
      // A restart swallows a coincident wrap, so no step and no tick
      step    = wrap && !restart;

      presc_d = presc_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      k_d     = k_q;
      dir_d   = dir_q;
      tick_d  = step;

      if (restart) begin
         presc_d = '0;
         cnt_d   = '0;
         pos_d   = '0;
         k_d     = '0;
         dir_d   = 1'b0;
      end else if (en) begin
         presc_d = presc_q + LOG2DELAY'(1);
         if (step) begin
            case (mode_e'(mode))
               MODE_BIN, MODE_GRAY: cnt_d = cnt_q + WIDTH'(1);
               MODE_SCAN: begin
                  // Turn around as the endpoint is entered so it shows once
                  if (!dir_q) begin
                     pos_d = pos_q + PW'(1);
                     if (pos_q == PW'(WIDTH - 2)) dir_d = 1'b1;
                  end else begin
                     pos_d = pos_q - PW'(1);
                     if (pos_q == PW'(1)) dir_d = 1'b0;
                  end
               end
               default: begin
                  if (!dir_q) begin
                     k_d = k_q + KW'(1);
                     if (k_q == KW'(WIDTH - 1)) dir_d = 1'b1;
                  end else begin
                     k_d = k_q - KW'(1);
                     if (k_q == KW'(1)) dir_d = 1'b0;
                  end
               end
            endcase
         end
      end

      // Pattern of the next state so leds changes on the same edge as state
      leds_d = pattern_of(mode, cnt_d, pos_d, k_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= 2'b00;
         presc_q <= '0;
         cnt_q   <= '0;
         pos_q   <= '0;
         k_q     <= '0;
         dir_q   <= 1'b0;
         leds_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         mode_q  <= mode;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         k_q     <= k_d;
         dir_q   <= dir_d;
         leds_q  <= leds_d;
         tick_q  <= tick_d;
      end
   end

   assign leds = leds_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Directed bench for led_pattern_gen with WIDTH=4, LOG2DELAY=2 (one step every
// four enabled cycles). Expected LED sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [3:0] leds;
   logic       tick;

   int checks;
   int errors;

   led_pattern_gen #(
      .WIDTH     (4),
      .LOG2DELAY (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .leds (leds),
      .tick (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock edge and sample 1 time unit later
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // One full step period: three quiet cycles showing prev, then the step edge
   task automatic period(input string tag, input logic [3:0] prev, input logic [3:0] nxt);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk({tag, "_hold_leds"}, leds, prev);
         chk({tag, "_hold_tick"}, {3'b0, tick}, 4'h0);
      end
      edge1();
      chk({tag, "_step_leds"}, leds, nxt);
      chk({tag, "_step_tick"}, {3'b0, tick}, 4'h1);
   endtask

   task automatic run_seq(input string tag, input logic [3:0] seq[$]);
      for (int i = 0; i + 1 < seq.size(); i++) period(tag, seq[i], seq[i+1]);
   endtask

   // Reset with mode 00, released mid-cycle; next edge is the first after release
   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b1;
      mode = 2'b00;
      edge1();
      chk("reset_leds", leds, 4'h0);
      chk("reset_tick", {3'b0, tick}, 4'h0);
      rst = 1'b0;
   endtask

   // Change mode right after reset release: first edge is a restart
   task automatic start_mode(input string tag, input logic [1:0] m, input logic [3:0] first);
      do_reset();
      mode = m;
      edge1();
      chk({tag, "_restart_leds"}, leds, first);
      chk({tag, "_restart_tick"}, {3'b0, tick}, 4'h0);
   endtask

   initial begin
      logic [3:0] seq_q[$];
      checks = 0;
      errors = 0;
      rst  = 1'b1;
      en   = 1'b1;
      mode = 2'b00;
      #2;
      chk("por_leds", leds, 4'h0);
      chk("por_tick", {3'b0, tick}, 4'h0);

      // BIN from reset: first step lands on the 4th edge after release
      do_reset();
      seq_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf, 4'h0};
      run_seq("bin", seq_q);

      // GRAY
      start_mode("gray", 2'b01, 4'h0);
      seq_q = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hc,
                4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8, 4'h0};
      run_seq("gray", seq_q);

      // SCAN
      start_mode("scan", 2'b10, 4'h1);
      seq_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
      run_seq("scan", seq_q);

      // BAR
      start_mode("bar", 2'b11, 4'h0);
      seq_q = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hf, 4'h7, 4'h3, 4'h1, 4'h0, 4'h1};
      run_seq("bar", seq_q);

      // en gating at BIN value 5: one cycle into the period, freeze for 10
      do_reset();
      seq_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      run_seq("gate_pre", seq_q);
      edge1();
      chk("gate_pre1_leds", leds, 4'h5);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge1();
         chk("gate_off_leds", leds, 4'h5);
         chk("gate_off_tick", {3'b0, tick}, 4'h0);
      end
      en = 1'b1;
      // Two prescaler counts remain quiet, the third enabled edge steps
      for (int i = 0; i < 2; i++) begin
         edge1();
         chk("gate_resume_leds", leds, 4'h5);
         chk("gate_resume_tick", {3'b0, tick}, 4'h0);
      end
      edge1();
      chk("gate_step_leds", leds, 4'h6);
      chk("gate_step_tick", {3'b0, tick}, 4'h1);

      // Mode switch to SCAN on the wrap cycle while BIN shows 9
      do_reset();
      seq_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
      run_seq("sw_pre", seq_q);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("sw_wait_leds", leds, 4'h9);
      end
      mode = 2'b10;
      edge1();
      chk("sw_restart_leds", leds, 4'h1);
      chk("sw_restart_tick", {3'b0, tick}, 4'h0);
      period("sw_scan", 4'h1, 4'h2);

      // Async reset between edges while tick is high
      #2;
      rst = 1'b1;
      #1;
      chk("async_leds", leds, 4'h0);
      chk("async_tick", {3'b0, tick}, 4'h0);
      mode = 2'b00;
      edge1();
      rst = 1'b0;
      seq_q = '{4'h0, 4'h1};
      run_seq("post_rst", seq_q);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
